mul_div_seq: RTL and testbench

- Iterative multi-cycle multiply/divide sequencer beside the single-cycle ALU in the execute stage.
- Takes unsigned multiply (low/high word) and unsigned divide/remainder off the combinational ALU path.
- Accepts one operation through a start/busy/done handshake, runs one radix-2 step per cycle, and holds the result until the next accepted start.
- The pipeline stalls execute while busy is high.

---
 rtl/mul_div_seq.sv | 116 +++++++++++
 tb/tb_mul_div_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative radix-2 multiply / divide sequencer.
// Unsigned mul lo/hi and divu/remu, one step per cycle.
module mul_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             fin;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] nxt_acc;
  logic [WIDTH-1:0] nxt_lo;

  // One shift-add or restoring-subtract step on {acc, lo}
  always_comb begin
    mul_sum  = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    div_sh   = {acc, lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
    if (op_r[1]) begin
      if (div_diff[WIDTH]) begin
        nxt_acc = div_sh[WIDTH-1:0];
        nxt_lo  = {lo[WIDTH-2:0], 1'b0};
      end else begin
        nxt_acc = div_diff[WIDTH-1:0];
        nxt_lo  = {lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      nxt_acc = mul_sum[WIDTH:1];
      nxt_lo  = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Sequencer FSM with registered busy/done/result
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      fin    <= 1'b0;
      op_r   <= '0;
      opnd   <= '0;
      acc    <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            op_r  <= op;
            opnd  <= op[1] ? b : a;
            lo    <= op[1] ? a : b;
            acc   <= '0;
            cnt   <= '0;
            fin   <= 1'b0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (fin) begin
            result <= op_r[0] ? acc : lo;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else begin
            busy <= 1'b1;
            acc  <= nxt_acc;
            lo   <= nxt_lo;
            cnt  <= cnt + 1'b1;
            fin  <= (cnt == CW'(WIDTH - 1));
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: vector table, corner sequences and
// randomized checks against an arithmetic model.
module tb_mul_div_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  mul_div_seq #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [1:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = 64'(x) * 64'(y);
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (y == 0) ? '1 : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic issue(input logic [1:0] o,
                       input logic [W-1:0] x,
                       input logic [W-1:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // lat = cycles from accept edge to done (0 if it never came)
  task automatic wait_done(output int lat,
                           output int bcnt,
                           output logic bat);
    lat  = 0;
    bcnt = 0;
    bat  = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        bat = busy;
        break;
      end
    end
  endtask

  task automatic no_done(input string name, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (done) seen++;
    end
    chk(name, seen, 0);
  endtask

  initial begin
    int   lat;
    int   bcnt;
    logic bat;
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int   sel;

    vecs[0] = '{2'd0, 32'd7,        32'd6,        32'd42};
    vecs[1] = '{2'd1, 32'd7,        32'd6,        32'd0};
    vecs[2] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[3] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[4] = '{2'd2, 32'd100,      32'd7,        32'd14};
    vecs[5] = '{2'd3, 32'd100,      32'd7,        32'd2};
    vecs[6] = '{2'd2, 32'h80000000, 32'd1,        32'h80000000};
    vecs[7] = '{2'd3, 32'h80000000, 32'd1,        32'd0};
    vecs[8] = '{2'd2, 32'd5,        32'd0,        32'hFFFFFFFF};
    vecs[9] = '{2'd3, 32'd5,        32'd0,        32'd5};

    rst   = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    rst = 1'b0;
    tick();

    // Directed vectors
    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt, bat);
      chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 33);
      chk($sformatf("vec%0d_busy_cycles", i), bcnt, 32);
      chk($sformatf("vec%0d_busy_at_done", i), bat, 0);
    end
    tick();
    chk("done_one_cycle", done, 0);
    tick();

    // Flush mid-run
    issue(2'd2, 32'd9, 32'd3);
    wait_done(lat, bcnt, bat);
    chk("pre_flush_result", result, 3);
    tick();
    issue(2'd2, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    no_done("flush_no_done", 40);
    chk("flush_result_held", result, 3);

    // Start pulsed mid-run is ignored
    issue(2'd2, 32'd100, 32'd7);
    for (int k = 0; k < 5; k++) tick();
    op    = 2'd0;
    a     = 32'd1;
    b     = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat   = 0;
    for (int k = 7; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("ignore_start_latency", lat, 33);
    chk("ignore_start_result", result, 14);
    tick();

    // Reset mid-run
    issue(2'd0, 32'd7, 32'd6);
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_result", result, 0);
    chk("rst_mid_busy", busy, 0);
    no_done("rst_mid_no_done", 40);

    // Back-to-back: start issued in the DONE cycle
    issue(2'd0, 32'd7, 32'd6);
    wait_done(lat, bcnt, bat);
    chk("b2b_first_result", result, 42);
    issue(2'd2, 32'd100, 32'd7);
    chk("b2b_busy_after_accept", busy, 0);
    wait_done(lat, bcnt, bat);
    chk("b2b_second_latency", lat, 33);
    chk("b2b_second_result", result, 14);
    tick();
    tick();

    // start together with flush is dropped
    op    = 2'd0;
    a     = 32'd3;
    b     = 32'd3;
    start = 1'b1;
    flush = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b0;
    tick();
    chk("start_flush_busy", busy, 0);
    no_done("start_flush_no_done", 40);
    chk("start_flush_result", result, 14);

    // Randomized against the model
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 7);
      ro  = 2'($urandom_range(0, 3));
      ra  = (sel == 2) ? 32'($urandom_range(0, 255)) : $urandom;
      if (sel == 0)      rb = '0;
      else if (sel == 1) rb = 32'($urandom_range(1, 15));
      else               rb = $urandom;
      issue(ro, ra, rb);
      wait_done(lat, bcnt, bat);
      chk($sformatf("rnd%0d_op%0d_result", i, ro),
          result, model(ro, ra, rb));
      chk($sformatf("rnd%0d_latency", i), lat, 33);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
